// File: rtl/rand_arbiter_pkg.sv
// rand_arbiter_pkg: shared types, constants and the LFSR tap table for the
// random-number arbiter. The optional fixed-priority mode is selected with
// the RAND_PRIO_EN macro in rand_arbiter.sv.
package rand_arbiter_pkg;

    // Width of the warm-up counter (WARMUP is limited to 0..255)
    localparam int WCNT_W = 8;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        WARM = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Maximal-length XNOR feedback taps per register width; bit n-1 set for tap n
    function automatic logic [31:0] lfsr_taps(input int unsigned dsize);
        logic [31:0] mask;
        case (dsize)
            32'd3:   mask = 32'h0000_0006;
            32'd4:   mask = 32'h0000_000C;
            32'd5:   mask = 32'h0000_0014;
            32'd6:   mask = 32'h0000_0030;
            32'd7:   mask = 32'h0000_0060;
            32'd8:   mask = 32'h0000_00B8;
            32'd9:   mask = 32'h0000_0110;
            32'd10:  mask = 32'h0000_0240;
            32'd11:  mask = 32'h0000_0500;
            32'd12:  mask = 32'h0000_0829;
            32'd13:  mask = 32'h0000_100D;
            32'd14:  mask = 32'h0000_2015;
            32'd15:  mask = 32'h0000_6000;
            32'd16:  mask = 32'h0000_D008;
            32'd17:  mask = 32'h0001_2000;
            32'd18:  mask = 32'h0002_0400;
            32'd19:  mask = 32'h0004_0023;
            32'd20:  mask = 32'h0009_0000;
            32'd21:  mask = 32'h0014_0000;
            32'd22:  mask = 32'h0030_0000;
            32'd23:  mask = 32'h0042_0000;
            32'd24:  mask = 32'h00E1_0000;
            32'd25:  mask = 32'h0120_0000;
            32'd26:  mask = 32'h0200_0023;
            32'd27:  mask = 32'h0400_0013;
            32'd28:  mask = 32'h0900_0000;
            32'd29:  mask = 32'h1400_0000;
            32'd30:  mask = 32'h2000_0029;
            32'd31:  mask = 32'h4800_0000;
            32'd32:  mask = 32'h8020_0003;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rand_arbiter_lfsr.sv
// rand_arbiter_lfsr: DSIZE-bit XNOR Fibonacci LFSR. Shifts left with the
// XNOR of the tap bits entering at the LSB; steps only when en_i is high.
module rand_arbiter_lfsr
    import rand_arbiter_pkg::*;
#(
    parameter int          DSIZE = 16,
    parameter logic [31:0] SEED  = 32'd896
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             en_i,
    output logic [DSIZE-1:0] lfsr_o
);

    localparam logic [31:0]      TAPS_FULL = lfsr_taps(DSIZE);
    localparam logic [DSIZE-1:0] TAPS      = TAPS_FULL[DSIZE-1:0];
    localparam logic [DSIZE-1:0] SEED_W    = SEED[DSIZE-1:0];

    logic [DSIZE-1:0] lfsr_q;
    logic             fb_s;

    assign fb_s   = ~(^(lfsr_q & TAPS));
    assign lfsr_o = lfsr_q;

    // Shift register: advance one step per enabled cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lfsr_q <= SEED_W;
        end else if (en_i) begin
            lfsr_q <= {lfsr_q[DSIZE-2:0], fb_s};
        end else begin
            lfsr_q <= lfsr_q;
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// rand_arbiter: hands distinct LFSR words to NREQ requesters, one per cycle,
// after a WARMUP-step warm-up. Default arbitration is round-robin; defining
// RAND_PRIO_EN selects lowest-index-first fixed priority (no pointer).
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int          NREQ   = 4,
    parameter int          DSIZE  = 16,
    parameter logic [31:0] SEED   = 32'd896,
    parameter int          WARMUP = 32
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [NREQ-1:0]  req_i,
    output logic             ready_o,
    output logic [NREQ-1:0]  gnt_o,
    output logic             rand_vld_o,
    output logic [DSIZE-1:0] rand_dat_o
);

    localparam int                PTR_W     = $clog2(NREQ);
    localparam state_e            RST_STATE = (WARMUP == 0) ? RUN : WARM;
    localparam logic [WCNT_W-1:0] WARM_LAST = (WARMUP == 0) ? {WCNT_W{1'b0}}
                                                            : WCNT_W'(WARMUP - 1);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               vld_q;
    logic [DSIZE-1:0]   dat_q;
    logic               ready_q;
    logic               warm_s;
    logic               win_s;
    logic [PTR_W-1:0]   win_idx_s;
    logic [NREQ-1:0]    elig_s;
    logic [NREQ-1:0]    rot_s;
    logic [DSIZE-1:0]   lfsr_s;
    int                 first_s;

`ifndef RAND_PRIO_EN
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_nxt_s;
    int                 sum_s;
`endif

    // State register plus warm-up counter
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= RST_STATE;
            cnt_q   <= {WCNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: leave warm-up after the last discarded advance
    always_comb begin
        state_d = state_q;
        case (state_q)
            WARM: begin
                if (cnt_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    state_d = WARM;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = RST_STATE;
        endcase
    end

    // FSM outputs: forced LFSR advance and counter increment during warm-up
    always_comb begin
        warm_s = 1'b0;
        cnt_d  = cnt_q;
        case (state_q)
            WARM: begin
                warm_s = 1'b1;
                cnt_d  = cnt_q + 8'd1;
            end
            RUN: begin
                warm_s = 1'b0;
                cnt_d  = cnt_q;
            end
            default: begin
                warm_s = 1'b0;
                cnt_d  = cnt_q;
            end
        endcase
    end

    // Last cycle's winner is masked so nobody wins twice in a row
    assign elig_s = (state_q == RUN) ? (req_i & ~gnt_q) : {NREQ{1'b0}};

`ifdef RAND_PRIO_EN
    assign rot_s = elig_s;
`else
    // Rotate so that bit 0 of rot_s is the requester the pointer names
    assign rot_s = NREQ'({elig_s, elig_s} >> ptr_q);
`endif

    // Lowest set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        win_s     = 1'b0;
        first_s   = 0;
        win_idx_s = {PTR_W{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                win_s   = 1'b1;
                first_s = i;
            end else begin
                win_s   = win_s;
            end
        end
`ifdef RAND_PRIO_EN
        win_idx_s = PTR_W'(first_s);
`else
        sum_s = first_s + int'(ptr_q);
        if (sum_s >= NREQ) begin
            sum_s = sum_s - NREQ;
        end else begin
            sum_s = sum_s;
        end
        win_idx_s = PTR_W'(sum_s);
`endif
    end

    assign gnt_d = win_s ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx_s) : {NREQ{1'b0}};

`ifndef RAND_PRIO_EN
    assign ptr_nxt_s = (win_idx_s == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}}
                                                       : win_idx_s + PTR_W'(1'b1);
`endif

    // Issue registers: grant, value and pointer update on a win
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            gnt_q   <= {NREQ{1'b0}};
            vld_q   <= 1'b0;
            dat_q   <= {DSIZE{1'b0}};
            ready_q <= 1'b0;
`ifndef RAND_PRIO_EN
            ptr_q   <= {PTR_W{1'b0}};
`endif
        end else begin
            ready_q <= (state_d == RUN);
            if (win_s) begin
                gnt_q <= gnt_d;
                vld_q <= 1'b1;
                dat_q <= lfsr_s;
`ifndef RAND_PRIO_EN
                ptr_q <= ptr_nxt_s;
`endif
            end else begin
                gnt_q <= {NREQ{1'b0}};
                vld_q <= 1'b0;
                dat_q <= dat_q;
            end
        end
    end

    rand_arbiter_lfsr #(
        .DSIZE (DSIZE),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (warm_s | win_s),
        .lfsr_o    (lfsr_s)
    );

    assign ready_o    = ready_q;
    assign gnt_o      = gnt_q;
    assign rand_vld_o = vld_q;
    assign rand_dat_o = dat_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter: scoreboard bench for rand_arbiter (NREQ=4, DSIZE=16,
// SEED=896). dut0 has WARMUP=0, dut32 has WARMUP=32. Expected responses are
// queued when stimulus is issued; negedge monitors pop and compare.
module tb_rand_arbiter;

    logic        clk = 1'b0;
    logic        rst0_n, rst32_n;
    logic [3:0]  req0, req32;
    logic        rdy0, rdy32, vld0, vld32;
    logic [3:0]  gnt0, gnt32;
    logic [15:0] dat0, dat32;

    typedef struct {
        int          cyc;
        logic [3:0]  gnt;
        logic [15:0] dat;
    } exp_t;

    exp_t        q0[$];
    exp_t        q32[$];
    exp_t        e0, e32;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_push0 = 0;
    int          n_seen0 = 0;
    logic [3:0]  m_gnt;
    logic [1:0]  m_ptr;
    logic [15:0] m_lfsr;
    logic [15:0] st33;

    rand_arbiter #(.NREQ(4), .DSIZE(16), .SEED(32'd896), .WARMUP(0)) dut0 (
        .clk_i(clk), .reset_n_i(rst0_n), .req_i(req0), .ready_o(rdy0),
        .gnt_o(gnt0), .rand_vld_o(vld0), .rand_dat_o(dat0));

    rand_arbiter #(.NREQ(4), .DSIZE(16), .SEED(32'd896), .WARMUP(32)) dut32 (
        .clk_i(clk), .reset_n_i(rst32_n), .req_i(req32), .ready_o(rdy32),
        .gnt_o(gnt32), .rand_vld_o(vld32), .rand_dat_o(dat32));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // x^16+x^15+x^13+x^4 XNOR LFSR, shifted left
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], ~(v[15] ^ v[14] ^ v[12] ^ v[3])};
    endfunction

    task automatic chk(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 'h%0h, want 'h%0h (cycle %0d)", name, act, want, cyc);
    endtask

    // Monitor for dut0
    always @(negedge clk) begin
        if (vld0) begin
            n_seen0++;
            chk("dut0 value expected", q0.size() != 0, {28'd0, gnt0}, 32'd0);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("dut0 cycle", cyc == e0.cyc, cyc, e0.cyc);
                chk("dut0 gnt", gnt0 == e0.gnt, {28'd0, gnt0}, {28'd0, e0.gnt});
                chk("dut0 dat", dat0 == e0.dat, {16'd0, dat0}, {16'd0, e0.dat});
            end
        end else begin
            chk("dut0 idle gnt", gnt0 == 4'b0000, {28'd0, gnt0}, 32'd0);
            if (q0.size() != 0) chk("dut0 missing value", q0[0].cyc > cyc, cyc, q0[0].cyc);
        end
    end

    // Monitor for dut32
    always @(negedge clk) begin
        if (vld32) begin
            chk("dut32 value expected", q32.size() != 0, {28'd0, gnt32}, 32'd0);
            if (q32.size() != 0) begin
                e32 = q32.pop_front();
                chk("dut32 cycle", cyc == e32.cyc, cyc, e32.cyc);
                chk("dut32 gnt", gnt32 == e32.gnt, {28'd0, gnt32}, {28'd0, e32.gnt});
                chk("dut32 dat", dat32 == e32.dat, {16'd0, dat32}, {16'd0, e32.dat});
            end
        end else begin
            chk("dut32 idle gnt", gnt32 == 4'b0000, {28'd0, gnt32}, 32'd0);
            if (q32.size() != 0) chk("dut32 missing value", q32[0].cyc > cyc, cyc, q32[0].cyc);
        end
    end

    // Directed step: hand-given grant (0 = none) and value for the next edge
    task automatic step_hand(input logic [3:0] r, input logic [3:0] g, input logic [15:0] d);
        req0 = r;
        if (g != 4'b0000) begin
            q0.push_back('{cyc + 1, g, d});
            n_push0++;
            m_lfsr = lfsr_next(m_lfsr);
            for (int k = 0; k < 4; k++) if (g[k]) m_ptr = 2'(k + 1);
        end
        m_gnt = g;
        @(negedge clk);
    endtask

    // Model step: derive the expected winner from the arbitration rules
    task automatic step0(input logic [3:0] r);
        logic [3:0] elig;
        logic       found;
        int         w;
        int         idx;
        req0  = r;
        elig  = r & ~m_gnt;
        found = 1'b0;
        w     = 0;
        for (int k = 0; k < 4; k++) begin
`ifdef RAND_PRIO_EN
            idx = k;
`else
            idx = (int'(m_ptr) + k) % 4;
`endif
            if (!found && elig[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        if (found) begin
            q0.push_back('{cyc + 1, 4'(4'b0001 << w), m_lfsr});
            n_push0++;
            m_lfsr = lfsr_next(m_lfsr);
            m_ptr  = 2'((w + 1) % 4);
            m_gnt  = 4'(4'b0001 << w);
        end else begin
            m_gnt = 4'b0000;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_gnt  = 4'b0000;
        m_ptr  = 2'd0;
        m_lfsr = 16'h0380;
    endtask

    initial begin
        rst0_n  = 1'b0;
        rst32_n = 1'b0;
        req0    = 4'b0000;
        req32   = 4'b1111;
        model_reset();
        st33 = 16'h0380;
        repeat (32) st33 = lfsr_next(st33);

        // Reset state of both instances
        #1;
        chk("rst gnt0", gnt0 == 4'b0000, {28'd0, gnt0}, 32'd0);
        chk("rst vld0", vld0 == 1'b0, {31'd0, vld0}, 32'd0);
        chk("rst dat0", dat0 == 16'h0000, {16'd0, dat0}, 32'd0);
        chk("rst ready0", rdy0 == 1'b0, {31'd0, rdy0}, 32'd0);
        chk("rst ready32", rdy32 == 1'b0, {31'd0, rdy32}, 32'd0);
        chk("rst dat32", dat32 == 16'h0000, {16'd0, dat32}, 32'd0);

        // Warm-up: 32 cycles without ready or grant, then the 33rd LFSR state
        repeat (2) @(negedge clk);
        rst32_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            chk("warm vld32", vld32 == 1'b0, {31'd0, vld32}, 32'd0);
            chk("warm ready32", rdy32 == (i == 32), {31'd0, rdy32}, (i == 32) ? 32'd1 : 32'd0);
            if (i == 32) q32.push_back('{cyc + 1, 4'b0001, st33});
        end
        @(negedge clk);
        req32 = 4'b0000;
        @(negedge clk);
        chk("ready32 held", rdy32 == 1'b1, {31'd0, rdy32}, 32'd1);

        // WARMUP=0, single requester: value, gap, next value
        rst0_n = 1'b1;
        step_hand(4'b0001, 4'b0001, 16'h0380);
        step_hand(4'b0001, 4'b0000, 16'h0000);
        step_hand(4'b0001, 4'b0001, 16'h0701);
        chk("ready0", rdy0 == 1'b1, {31'd0, rdy0}, 32'd1);
        step_hand(4'b0000, 4'b0000, 16'h0000);

        // Mid-stream asynchronous reset
        repeat (3) step0(4'b1111);
        #2;
        rst0_n = 1'b0;
        q0.delete();
        n_push0 = n_seen0;
        #1;
        chk("async rst gnt0", gnt0 == 4'b0000, {28'd0, gnt0}, 32'd0);
        chk("async rst vld0", vld0 == 1'b0, {31'd0, vld0}, 32'd0);
        chk("async rst dat0", dat0 == 16'h0000, {16'd0, dat0}, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;

`ifdef RAND_PRIO_EN
        step_hand(4'b0011, 4'b0001, 16'h0380);
        step_hand(4'b0011, 4'b0010, m_lfsr);
        step_hand(4'b0011, 4'b0001, m_lfsr);
        step_hand(4'b0011, 4'b0010, m_lfsr);
        step_hand(4'b0101, 4'b0001, m_lfsr);
        step_hand(4'b0101, 4'b0100, m_lfsr);
        step_hand(4'b0101, 4'b0001, m_lfsr);
        step_hand(4'b0101, 4'b0100, m_lfsr);
`else
        step_hand(4'b1111, 4'b0001, 16'h0380);
        step_hand(4'b1111, 4'b0010, m_lfsr);
        step_hand(4'b1111, 4'b0100, m_lfsr);
        step_hand(4'b1111, 4'b1000, m_lfsr);
        step_hand(4'b1111, 4'b0001, m_lfsr);
`endif

        // Random request patterns against the model
        for (int n = 0; n < 10000; n++) step0(4'($urandom_range(0, 15)));
        repeat (2) step0(4'b0000);

        chk("dut0 queue drained", q0.size() == 0, q0.size(), 32'd0);
        chk("dut32 queue drained", q32.size() == 0, q32.size(), 32'd0);
        chk("dut0 value count", n_seen0 == n_push0, n_seen0, n_push0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
